// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder with a 256-byte RAM,
// a read-only pattern ROM window and a fixed number of wait states.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_we, req_burst     store / 4-byte burst load select
//   req_a, req_d          byte address, store data
//   rsp_valid/rsp_ready   response handshake (response held until consumed)
//   rsp_q0..rsp_q3        load data lanes (q0 only for single loads)
//   rsp_err               access faulted
//
// Address map: 0x0000-0x00FF RAM, 0x1000-0x10FF ROM (a[7:0]^0x5A), rest unmapped.

// One byte lane: decodes its own address so a burst may straddle regions.
module mem_lane (
  input  logic [15:0] lane_a,
  input  logic [7:0]  ram_q,
  input  logic        en,
  input  logic        we,
  output logic [7:0]  q,
  output logic        fault
);
  logic in_ram, in_rom;
  assign in_ram = (lane_a[15:8] == 8'h00);
  assign in_rom = (lane_a[15:8] == 8'h10);

  always_comb begin
    q     = '0;
    fault = 1'b0;
    if (en) begin
      if (we)          fault = !in_ram;  // ROM and unmapped are not writable
      else if (in_ram) q     = ram_q;
      else if (in_rom) q     = lane_a[7:0] ^ 8'h5A;
      else             fault = 1'b1;
    end
  end
endmodule

module mem_responder #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_burst,
  input  logic [15:0] req_a,
  input  logic [7:0]  req_d,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_q0,
  output logic [7:0]  rsp_q1,
  output logic [7:0]  rsp_q2,
  output logic [7:0]  rsp_q3,
  output logic        rsp_err
);
  localparam int         NUM_LANES = 4;
  localparam logic [2:0] CNT_INIT  = 3'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic        burst;
    logic [15:0] a;
    logic [7:0]  d;
  } req_t;

  state_t state_q, state_d;
  logic [2:0] cnt_q;
  req_t req_q, req_in, src;
  logic accept, enter_resp;

  logic [7:0] ram [256];

  logic [NUM_LANES-1:0][15:0] lane_a;
  logic [NUM_LANES-1:0][7:0]  lane_rd, lane_q, rsp_q;
  logic [NUM_LANES-1:0]       lane_fault;
  logic                       err;

  assign req_in = '{we: req_we, burst: req_burst, a: req_a, d: req_d};

  // With zero wait states the response is built on the accepting edge, so
  // the access is decoded from the live request rather than the latch.
  assign src = (state_q == IDLE) ? req_in : req_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    req_ready  = (state_q == IDLE);
    rsp_valid  = (state_q == RESP);
    case (state_q)
      IDLE: if (req_valid) begin
        accept = 1'b1;
        if (WAIT_CYCLES == 0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: if (cnt_q <= 3'd1) begin
        state_d    = RESP;
        enter_resp = 1'b1;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      req_q <= '0;
    end else begin
      if (accept) begin
        cnt_q <= CNT_INIT;
        req_q <= req_in;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - 3'd1;
      end
    end
  end

  genvar k;
  generate
    for (k = 0; k < NUM_LANES; k++) begin : g_lane
      assign lane_a[k]  = src.a + 16'(k);   // wraps mod 2^16
      assign lane_rd[k] = ram[lane_a[k][7:0]];
      mem_lane u_lane (
        .lane_a (lane_a[k]),
        .ram_q  (lane_rd[k]),
        .en     ((k == 0) || src.burst),
        .we     (src.we),
        .q      (lane_q[k]),
        .fault  (lane_fault[k])
      );
    end
  endgenerate

  assign err = (|lane_fault) | (src.burst & src.we);

  // Store only a clean single-byte RAM store; any fault leaves RAM untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
    end else if (enter_resp && src.we && !src.burst && !lane_fault[0]) begin
      ram[src.a[7:0]] <= src.d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_q   <= '0;
      rsp_err <= 1'b0;
    end else if (enter_resp) begin
      rsp_q   <= lane_q;
      rsp_err <= err;
    end
  end

  assign rsp_q0 = rsp_q[0];
  assign rsp_q1 = rsp_q[1];
  assign rsp_q2 = rsp_q[2];
  assign rsp_q3 = rsp_q[3];
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, wait states inserted between request acceptance and response (legal 0..7).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  initiator presents a request.
REQ-005 req_ready  output  1  responder can accept a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_burst  input  1  load of 4 consecutive bytes (a, a+1, a+2, a+3).
REQ-008 req_a  input  16  byte address.
REQ-009 req_d  input  8  store data.
REQ-010 rsp_valid  output  1  response held on outputs.
REQ-011 rsp_ready  input  1  initiator consumes the response.
REQ-012 rsp_q0, rsp_q1, rsp_q2, rsp_q3  output  8 each  load data; q0 only for single loads, q0..q3 for bursts.
REQ-013 rsp_err  output  1  access faulted.

Function
REQ-014 Address map: RAM 0x0000-0x00FF (256x8 internal, read/write); ROM window 0x1000-0x10FF (read-only, byte value = a[7:0] XOR 8'h5A); all other addresses unmapped.
REQ-015 FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE; rsp_valid = 1 only in RESP.
REQ-016 IDLE: on req_valid & req_ready, latch req_we, req_burst, req_a, req_d; go to WAIT with counter = WAIT_CYCLES if WAIT_CYCLES > 0, else directly to RESP.
REQ-017 WAIT: counter decrements each cycle; on the cycle the counter equals 1, go to RESP.
REQ-018 Latency: rsp_valid rises exactly WAIT_CYCLES+1 rising edges after the accepting edge.
REQ-019 Load data and rsp_err are computed and registered on the edge entering RESP, then held stable while in RESP.
REQ-020 Store commits to RAM on the edge entering RESP; rsp_q0..q3 = 0 for stores.
REQ-021 RESP: remain until rsp_ready = 1; on that edge go to IDLE; no new request is accepted on that same edge (req_ready = 0 in RESP).
REQ-022 Single load: rsp_q0 = mapped byte at latched address; rsp_q1..q3 = 0.
REQ-023 Burst load: byte k (0..3) from address (a+k) mod 2^16; each byte is decoded independently, so a burst may span RAM/ROM/unmapped.
REQ-024 Fault: rsp_err = 1 if any accessed byte is unmapped, store targets ROM window, or req_burst & req_we both set; faulting byte lanes read 0; a faulting store does not modify RAM.
REQ-025 Burst + store is a fault; no RAM byte is written.
REQ-026 Address wrap: burst at 0xFFFE reads 0xFFFE, 0xFFFF (unmapped), 0x0000, 0x0001 (RAM); rsp_err = 1, lanes 2-3 valid RAM data.
REQ-027 Request inputs are ignored outside IDLE; holding req_valid high through a response causes re-acceptance on the first IDLE cycle.

Reset
REQ-028 rst asserted: FSM to IDLE, counter 0, latched request cleared, rsp_valid = 0, rsp_err = 0, rsp_q0..q3 = 0, all 256 RAM bytes = 0; req_ready = 1 on first cycle after release.
REQ-029 Reset mid-operation (WAIT or RESP): pending store discarded (RAM still cleared), pending response lost, no rsp_valid pulse after release.

Verification
REQ-030 WAIT_CYCLES=1: store 0x3C to 0x0042, then single load 0x0042 -> rsp_q0 = 0x3C, rsp_err = 0, rsp_valid 2 edges after each accept.
REQ-031 Burst load 0x1010 -> q0..q3 = 0x4A, 0x4B, 0x48, 0x49, rsp_err = 0.
REQ-032 Store 0x77 to 0x1005 -> rsp_err = 1; subsequent load 0x1005 returns 0x5F (window unchanged); store to 0x2000 -> rsp_err = 1.
REQ-033 After storing 0x11 to 0x0000 and 0x22 to 0x0001: burst load 0xFFFE -> q0 = 0, q1 = 0, q2 = 0x11, q3 = 0x22, rsp_err = 1.
REQ-034 Back-pressure: hold rsp_ready = 0 for 5 cycles -> rsp_valid and data stable, req_ready = 0 throughout; release -> IDLE next edge.
REQ-035 Store 0x99 to 0x0010, assert rst during WAIT -> no response after release, load 0x0010 returns 0x00; WAIT_CYCLES=0 run gives rsp_valid 1 edge after accept.
